// File: rtl/bram_dp.sv
`default_nettype none
// =============================================================================
// bram_dp : dual-port byte-enable block RAM, configurable read latency, zero-fill
// Rev 1.0
// =============================================================================
module bram_dp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16384,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1,
  parameter int WR_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  a_rd_en,
  input  logic                  a_wr_en,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_rd_en,
  input  logic [ADDR_W-1:0]     b_addr,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_rvalid,
  output logic                  err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int IDX_W  = ADDR_W - OFF_W;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            r_state;
  logic [MEM_AW-1:0] r_cnt;

  logic [IDX_W-1:0]  w_a_idx, w_b_idx;
  logic [MEM_AW-1:0] w_a_word, w_b_word;
  logic              w_a_oor, w_b_oor, w_a_mis, w_b_mis;
  logic              w_ready, w_a_rd, w_a_wr, w_b_rd, w_err;
  logic [DATA_W-1:0] w_a_old, w_a_merged, w_a_rdval, w_b_rdval;

  logic              r_a_v1, r_b_v1;
  logic [DATA_W-1:0] r_a_d1, r_b_d1;

  assign w_a_idx  = a_addr[ADDR_W-1:OFF_W];
  assign w_b_idx  = b_addr[ADDR_W-1:OFF_W];
  assign w_a_word = w_a_idx[MEM_AW-1:0];
  assign w_b_word = w_b_idx[MEM_AW-1:0];

  // DEPTH is a power of two, so any set bit above the array index is out of range
  generate
    if (IDX_W > MEM_AW) begin : g_range
      assign w_a_oor = |w_a_idx[IDX_W-1:MEM_AW];
      assign w_b_oor = |w_b_idx[IDX_W-1:MEM_AW];
    end else begin : g_full
      assign w_a_oor = 1'b0;
      assign w_b_oor = 1'b0;
    end
  endgenerate

  generate
    if (OFF_W > 0) begin : g_sub
      assign w_a_mis = |a_addr[OFF_W-1:0];
      assign w_b_mis = |b_addr[OFF_W-1:0];
    end else begin : g_word
      assign w_a_mis = 1'b0;
      assign w_b_mis = 1'b0;
    end
  endgenerate

  assign w_ready = (r_state == S_READY);
  assign w_a_rd  = w_ready & a_rd_en;
  assign w_a_wr  = w_ready & a_wr_en & ~w_a_oor;
  assign w_b_rd  = w_ready & b_rd_en;
  assign w_err   = (w_ready & (a_rd_en | a_wr_en) & (w_a_oor | w_a_mis)) |
                   (w_ready & b_rd_en & (w_b_oor | w_b_mis));

  always_comb begin
    w_a_old    = mem[w_a_word];
    w_a_merged = w_a_old;
    for (int i = 0; i < BE_W; i++) begin
      if (a_be[i]) w_a_merged[8*i +: 8] = a_wdata[8*i +: 8];
    end
    if (w_a_oor)                    w_a_rdval = '0;
    else if (WR_MODE == 1 && w_a_wr) w_a_rdval = w_a_merged;
    else                            w_a_rdval = w_a_old;
    w_b_rdval = w_b_oor ? '0 : mem[w_b_word];
  end

  // Storage carries no reset so it maps onto block RAM; zeroing is done by the sequencer
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      mem[r_cnt] <= '0;
    end else if (w_a_wr) begin
      for (int i = 0; i < BE_W; i++) begin
        if (a_be[i]) mem[w_a_word][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      busy    <= 1'b1;
      err     <= 1'b0;
    end else begin
      err <= w_err;
      case (r_state)
        S_CLEAR: begin
          if (&r_cnt) begin
            r_state <= S_READY;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY: begin
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_v1 <= 1'b0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_rd;
      r_b_v1 <= w_b_rd;
      if (w_a_rd) r_a_d1 <= w_a_rdval;
      if (w_b_rd) r_b_d1 <= w_b_rdval;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_a_v2, r_b_v2;
      logic [DATA_W-1:0] r_a_d2, r_b_d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_v2 <= 1'b0;
          r_b_d2 <= '0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) r_a_d2 <= r_a_d1;
          if (r_b_v1) r_b_d2 <= r_b_d1;
        end
      end

      assign a_rvalid = r_a_v2;
      assign a_rdata  = r_a_d2;
      assign b_rvalid = r_b_v2;
      assign b_rdata  = r_b_d2;
    end else begin : g_lat1
      assign a_rvalid = r_a_v1;
      assign a_rdata  = r_a_d1;
      assign b_rvalid = r_b_v1;
      assign b_rdata  = r_b_d1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_dp.sv
`default_nettype none
// =============================================================================
// tb_bram_dp : checks two bram_dp builds (lat1/read-first, lat2/write-first)
// Rev 1.0
// =============================================================================
module tb_bram_dp;
  localparam int DEPTH = 1024;
  localparam int AW    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        a_rd_en = 1'b0, a_wr_en = 1'b0, b_rd_en = 1'b0;
  logic [3:0]  a_be = 4'h0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0;

  logic        busy0, busy1, a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1, err0, err1;
  logic [31:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_dp #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(1), .WR_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
    .err(err0)
  );

  bram_dp #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LAT(2), .WR_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .a_rd_en(a_rd_en), .a_wr_en(a_wr_en), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
    .err(err1)
  );

  // Reference model: word array plus clear countdown; results delayed per latency
  logic [31:0] mdl [DEPTH];
  int          clr_left;
  logic        x_a0v, x_b0v, x_a1v, x_b1v, s_a1v, s_b1v, x_err;
  logic [31:0] x_a0d, x_b0d, x_a1d, x_b1d, s_a1d, s_b1d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_zero();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
  endtask

  task automatic model_step();
    int ai, bi;
    logic na_v, nb_v, n_err;
    logic [31:0] na0, na1, nb, old, nw;
    if (rst) begin
      clr_left = DEPTH;
      mdl_zero();
      {x_a0v, x_b0v, x_a1v, x_b1v, s_a1v, s_b1v, x_err} = '0;
      {x_a0d, x_b0d, x_a1d, x_b1d, s_a1d, s_b1d} = '0;
      return;
    end
    x_a1v = s_a1v; if (s_a1v) x_a1d = s_a1d;
    x_b1v = s_b1v; if (s_b1v) x_b1d = s_b1d;
    na_v = 0; nb_v = 0; n_err = 0; na0 = 0; na1 = 0; nb = 0;
    if (clr_left > 0) begin
      clr_left--;
    end else begin
      ai = int'(a_addr) / 4;
      bi = int'(b_addr) / 4;
      if ((a_rd_en || a_wr_en) && (ai >= DEPTH || (int'(a_addr) % 4) != 0)) n_err = 1;
      if (b_rd_en && (bi >= DEPTH || (int'(b_addr) % 4) != 0)) n_err = 1;
      old = (ai < DEPTH) ? mdl[ai] : 32'h0;
      nw  = old;
      for (int k = 0; k < 4; k++) if (a_be[k]) nw[8*k +: 8] = a_wdata[8*k +: 8];
      if (a_rd_en) begin
        na_v = 1;
        na0  = old;
        na1  = (a_wr_en && ai < DEPTH) ? nw : old;
      end
      if (b_rd_en) begin
        nb_v = 1;
        nb   = (bi < DEPTH) ? mdl[bi] : 32'h0;
      end
      if (a_wr_en && ai < DEPTH) mdl[ai] = nw;
      if (clr_req) begin
        clr_left = DEPTH;
        mdl_zero();
      end
    end
    x_a0v = na_v; if (na_v) x_a0d = na0;
    x_b0v = nb_v; if (nb_v) x_b0d = nb;
    s_a1v = na_v; s_a1d = na1;
    s_b1v = nb_v; s_b1d = nb;
    x_err = n_err;
  endtask

  task automatic check_all();
    chk("busy0", busy0, clr_left > 0);
    chk("busy1", busy1, clr_left > 0);
    chk("err0", err0, x_err);
    chk("err1", err1, x_err);
    chk("a_rvalid0", a_rvalid0, x_a0v);
    chk("a_rdata0", a_rdata0, x_a0d);
    chk("b_rvalid0", b_rvalid0, x_b0v);
    chk("b_rdata0", b_rdata0, x_b0d);
    chk("a_rvalid1", a_rvalid1, x_a1v);
    chk("a_rdata1", a_rdata1, x_a1d);
    chk("b_rvalid1", b_rvalid1, x_b1v);
    chk("b_rdata1", b_rdata1, x_b1d);
  endtask

  // Inputs are set at a falling edge; tick advances one rising edge and checks
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (!rst) check_all();
  endtask

  task automatic idle();
    a_rd_en = 0; a_wr_en = 0; b_rd_en = 0; clr_req = 0;
    a_be = 4'h0; a_addr = '0; b_addr = '0; a_wdata = '0;
  endtask

  task automatic wait_ready(input string nm, input int start);
    int n;
    n = start;
    while (busy0 === 1'b1 && n < DEPTH + 20) begin
      n++;
      tick();
    end
    chk(nm, n, DEPTH);
  endtask

  typedef struct {
    logic        a_rd, a_wr;
    logic [3:0]  be;
    logic [15:0] aa;
    logic [31:0] wd;
    logic        b_rd;
    logic [15:0] ba;
    logic [31:0] ea0, ea1, eb;
    logic        ee;
  } vec_t;

  function automatic vec_t mk(logic ar, logic aw, logic [3:0] be, logic [15:0] aa,
                              logic [31:0] wd, logic br, logic [15:0] ba,
                              logic [31:0] ea0, logic [31:0] ea1, logic [31:0] eb,
                              logic ee);
    vec_t v;
    v.a_rd = ar; v.a_wr = aw; v.be = be; v.aa = aa; v.wd = wd;
    v.b_rd = br; v.ba = ba; v.ea0 = ea0; v.ea1 = ea1; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = mk(1, 0, 4'h0, 16'h0000, 32'h0,        1, 16'h0800, 32'h0, 32'h0, 32'h0, 0);
    tbl[1]  = mk(1, 0, 4'h0, 16'h0FFC, 32'h0,        1, 16'h0FFC, 32'h0, 32'h0, 32'h0, 0);
    tbl[2]  = mk(0, 1, 4'hF, 16'h0010, 32'hAABBCCDD, 0, 16'h0,    32'h0, 32'h0, 32'h0, 0);
    tbl[3]  = mk(0, 1, 4'h5, 16'h0010, 32'h11223344, 0, 16'h0,    32'h0, 32'h0, 32'h0, 0);
    tbl[4]  = mk(0, 0, 4'h0, 16'h0,    32'h0,        1, 16'h0010, 32'h0, 32'h0, 32'hAA22CC44, 0);
    tbl[5]  = mk(0, 1, 4'hF, 16'h0020, 32'h9,        0, 16'h0,    32'h0, 32'h0, 32'h0, 0);
    tbl[6]  = mk(1, 1, 4'hF, 16'h0020, 32'h5,        1, 16'h0020, 32'h9, 32'h5, 32'h9, 0);
    tbl[7]  = mk(1, 0, 4'h0, 16'h0020, 32'h0,        1, 16'h0020, 32'h5, 32'h5, 32'h5, 0);
    tbl[8]  = mk(1, 0, 4'h0, 16'h0013, 32'h0,        0, 16'h0, 32'hAA22CC44, 32'hAA22CC44, 32'h0, 1);
    tbl[9]  = mk(0, 1, 4'hF, 16'h1F40, 32'hDEADBEEF, 0, 16'h0,    32'h0, 32'h0, 32'h0, 1);
    tbl[10] = mk(1, 0, 4'h0, 16'h1F40, 32'h0,        1, 16'h1F40, 32'h0, 32'h0, 32'h0, 1);
    tbl[11] = mk(0, 1, 4'h0, 16'h0010, 32'hFFFFFFFF, 0, 16'h0,    32'h0, 32'h0, 32'h0, 0);
    tbl[12] = mk(1, 0, 4'h0, 16'h0010, 32'h0, 1, 16'h0010, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 0);
    tbl[13] = mk(1, 1, 4'h3, 16'h0020, 32'h1234ABCD, 1, 16'h0020, 32'h5, 32'h0000ABCD, 32'h5, 0);
    tbl[14] = mk(0, 0, 4'h0, 16'h0,    32'h0,        1, 16'h0022, 32'h0, 32'h0, 32'h0000ABCD, 1);

    // Reset values and the post-reset zero-fill length
    idle();
    rst = 1;
    tick();
    tick();
    chk("rst_busy", busy0, 1'b1);
    chk("rst_a_rdata", a_rdata0, 32'h0);
    chk("rst_a_rvalid", a_rvalid1, 1'b0);
    chk("rst_b_rdata", b_rdata1, 32'h0);
    chk("rst_err", err0, 1'b0);
    rst = 0;
    wait_ready("busy_len_reset", 0);

    for (int i = 0; i < NV; i++) begin
      a_rd_en = tbl[i].a_rd; a_wr_en = tbl[i].a_wr; a_be = tbl[i].be;
      a_addr = tbl[i].aa; a_wdata = tbl[i].wd; b_rd_en = tbl[i].b_rd; b_addr = tbl[i].ba;
      tick();
      if (tbl[i].a_rd) begin
        chk($sformatf("v%0d_a0_vld", i), a_rvalid0, 1'b1);
        chk($sformatf("v%0d_a0_dat", i), a_rdata0, tbl[i].ea0);
      end
      if (tbl[i].b_rd) begin
        chk($sformatf("v%0d_b0_vld", i), b_rvalid0, 1'b1);
        chk($sformatf("v%0d_b0_dat", i), b_rdata0, tbl[i].eb);
      end
      chk($sformatf("v%0d_err0", i), err0, tbl[i].ee);
      chk($sformatf("v%0d_err1", i), err1, tbl[i].ee);
      chk($sformatf("v%0d_a1_early", i), a_rvalid1, 1'b0);
      idle();
      tick();
      if (tbl[i].a_rd) begin
        chk($sformatf("v%0d_a1_vld", i), a_rvalid1, 1'b1);
        chk($sformatf("v%0d_a1_dat", i), a_rdata1, tbl[i].ea1);
      end
      if (tbl[i].b_rd) begin
        chk($sformatf("v%0d_b1_vld", i), b_rvalid1, 1'b1);
        chk($sformatf("v%0d_b1_dat", i), b_rdata1, tbl[i].eb);
      end
      chk($sformatf("v%0d_err_once", i), err0, 1'b0);
    end

    // Randomised traffic on a small window with occasional misaligned/out-of-range hits
    for (int n = 0; n < 400; n++) begin
      int wa, wb, ra, rb;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      wa = (ra == 0) ? $urandom_range(DEPTH, 16383) : $urandom_range(0, 15);
      wb = (rb == 0) ? $urandom_range(DEPTH, 16383) : $urandom_range(0, 15);
      a_rd_en = 1'($urandom_range(0, 1));
      a_wr_en = 1'($urandom_range(0, 1));
      b_rd_en = 1'($urandom_range(0, 1));
      a_be    = 4'($urandom);
      a_wdata = $urandom;
      a_addr  = 16'(wa * 4 + ((ra == 1) ? $urandom_range(1, 3) : 0));
      b_addr  = 16'(wb * 4 + ((rb == 1) ? $urandom_range(1, 3) : 0));
      tick();
    end
    idle();
    tick();

    // Fill words 0..7, request a clear, keep issuing reads while busy
    for (int i = 0; i < 8; i++) begin
      a_wr_en = 1; a_be = 4'hF; a_addr = 16'(i * 4); a_wdata = 32'h01010101 * (i + 1);
      tick();
    end
    idle();
    clr_req = 1;
    tick();
    clr_req = 0;
    chk("clr_busy_rise", busy0, 1'b1);
    a_rd_en = 1; b_rd_en = 1; a_addr = 16'h0004; b_addr = 16'h0008;
    tick();
    chk("clr_no_rvalid", a_rvalid0, 1'b0);
    wait_ready("busy_len_clr", 1);
    idle();
    for (int i = 0; i < 8; i++) begin
      a_rd_en = 1; a_addr = 16'(i * 4);
      tick();
      chk($sformatf("clr_word%0d", i), a_rdata0, 32'h0);
    end
    idle();
    tick();

    // Reset partway through a clear restarts the full fill
    clr_req = 1;
    tick();
    clr_req = 0;
    repeat (100) tick();
    rst = 1;
    tick();
    rst = 0;
    wait_ready("busy_len_midreset", 0);

    // Streaming reads through the two-cycle pipeline
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_be = 4'hF; a_addr = 16'(i * 4); a_wdata = 32'h100 + i;
      tick();
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        a_rd_en = 1; a_addr = 16'(k * 4);
      end else begin
        idle();
      end
      tick();
      chk($sformatf("stream_vld%0d", k), a_rvalid1, (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk($sformatf("stream_dat%0d", k), a_rdata1, 32'h100 + k - 1);
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_dp.md
Name: bram_dp

Overview:
- Parametrised dual-port block RAM that replaces the single-port word memory used for instruction and data storage in the CPU.
- Port A is read/write with byte enables; port B is read-only, intended for instruction fetch.
- Adds configurable read latency, per-port read-valid strobes, and a hardware clear sequencer.
- Zero-fill runs one word per cycle after reset or on request, replacing an all-at-once reset clear.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words; must be a power of two.
- ADDR_W, 16, byte-address width; must satisfy 2^ADDR_W >= DEPTH*DATA_W/8.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_MODE, 0, port A same-address read/write result: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clr_req, input, 1: one-cycle pulse that starts a zero-fill when READY.
- busy, output, 1: high while a clear is in progress.
- a_rd_en, input, 1: port A read request.
- a_wr_en, input, 1: port A write request.
- a_be, input, DATA_W/8: port A byte enables; bit i selects byte i.
- a_addr, input, ADDR_W: port A byte address.
- a_wdata, input, DATA_W: port A write data.
- a_rdata, output, DATA_W: port A read data.
- a_rvalid, output, 1: pulses with valid a_rdata.
- b_rd_en, input, 1: port B read request.
- b_addr, input, ADDR_W: port B byte address.
- b_rdata, output, DATA_W: port B read data.
- b_rvalid, output, 1: pulses with valid b_rdata.
- err, output, 1: one-cycle pulse on an out-of-range or misaligned access on either port.

Behaviour:
- Word index = addr >> log2(DATA_W/8). Address bits below the word boundary are ignored for indexing.
- Reset (rst=1, async):
  - FSM enters CLEAR with the clear counter at 0.
  - busy=1; a_rdata, b_rdata = 0; a_rvalid, b_rvalid, err = 0.
  - Pipeline registers are cleared.
- FSM states:
  - CLEAR: each cycle writes zero to memory[cnt], then cnt++. After cnt reaches DEPTH-1 and that word is written, the next state is READY. Clear takes exactly DEPTH cycles after reset release.
  - READY: normal access. clr_req=1 sets cnt=0 and moves to CLEAR on the next edge; busy rises that same edge.
- In CLEAR:
  - All rd_en and wr_en requests are dropped; no rvalid and no err are produced.
  - Reads already in the READ_LAT=2 pipeline still complete.
  - clr_req is ignored.
- Reset mid-clear restarts the clear from word 0.
- Writes:
  - Accepted when READY, a_wr_en=1 and the word index < DEPTH.
  - Only bytes with a_be[i]=1 are updated.
  - a_be = 0 performs no write and is not an error.
- Reads:
  - Accepted when READY, rd_en=1 and the word index < DEPTH.
  - Data and rvalid appear READ_LAT cycles after the request edge.
  - rdata holds its last value when no read completes.
  - Back-to-back reads give one result per cycle.
- Range error:
  - Word index >= DEPTH on an enabled access: the write is dropped, the read returns 0 with rvalid asserted, and err pulses aligned to the request cycle + 1.
  - Only reachable when 2^ADDR_W exceeds the memory size.
- Misalignment:
  - Nonzero sub-word address bits on an enabled access pulse err.
  - The access still proceeds on the truncated word index.
- Collisions:
  - Port A write and port B read to the same word in the same cycle: B returns the old data.
  - Port A read and write to the same word in the same cycle: WR_MODE=0 returns the old word; WR_MODE=1 returns the merged new word, with unselected bytes keeping their old value.
  - Port A and port B both reading the same word: both return the same data.
- Inferred storage must map to vendor block RAM: no reset on the memory array, and the clear is performed only by the FSM.

Test Plan:
- Reset then wait: rst released at t0 -> busy=1 for exactly DEPTH cycles. Afterwards a read of words 0, DEPTH/2 and DEPTH-1 returns 0x00000000 with a_rvalid at +READ_LAT.
- Byte-enable write:
  - Write 0xAABBCCDD to addr 0x10 with be=4'hF, then 0x11223344 with be=4'b0101.
  - Read on port B -> 0xAA22CC44 with b_rvalid asserted READ_LAT cycles after b_rd_en.
- Collisions:
  - Same-cycle A write 0x5 and B read of addr 0x20 (old value 0x9) -> b_rdata=0x9; the next B read returns 0x5.
  - Repeat on port A with simultaneous rd+wr: WR_MODE=0 -> 0x9, WR_MODE=1 -> 0x5.
- clr_req after filling words 0..7 with nonzero data:
  - busy rises next cycle; requests issued during busy produce no rvalid.
  - After DEPTH cycles, all words read 0.
- Error cases:
  - Misaligned read at addr 0x13 -> data of word 4 returned and err pulses once.
  - With DEPTH=1024, ADDR_W=16, a write to word 2000 is dropped, a read there returns 0 with rvalid, and err pulses.
- Mid-clear reset and latency:
  - Assert rst at clear count 100 -> after release, the clear restarts and busy lasts the full DEPTH cycles.
  - With READ_LAT=2, streaming reads of words 0..3 -> rvalid high for 4 consecutive cycles starting 2 cycles after the first request.
